// File: rtl/dmem_wait_ctrl.sv
// Word-organised data memory with req/ack handshake, LATENCY wait states and a dump engine.
// Optional feature macro: DMEM_BYTE_STROBE_EN adds the dm_be byte-enable port.
module dmem_wait_ctrl #(
  parameter int N       = 64,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dm_req,
  input  logic                     dm_we,
  input  logic [N-1:0]             dm_addr,
  input  logic [N-1:0]             dm_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [N/8-1:0]           dm_be,
`endif
  output logic                     dm_ack,
  output logic [N-1:0]             dm_rdata,
  output logic                     dm_err,
  output logic                     dm_stall,
  input  logic                     dump,
  output logic                     dump_valid,
  output logic [$clog2(DEPTH)-1:0] dump_idx,
  output logic [N-1:0]             dump_data,
  output logic                     dump_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int B  = $clog2(N / 8);
  localparam int NB = N / 8;
  localparam logic [AW:0] PTR_END = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DUMP} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW:0]    ptr_q, ptr_d;
  logic           pend_q, pend_d;
  logic           dump_q;
  logic           dump_valid_q, dump_done_q;
  logic [AW-1:0]  dump_idx_q;

  logic [AW-1:0]  idx_q;
  logic           we_q, err_q;
  logic [N-1:0]   wdata_q;
  logic [NB-1:0]  wr_be;

  logic           accept, ack, wr_en, dump_rise, pend_eff, in_range_err;
  logic [AW-1:0]  rd_addr;
  logic [N-1:0]   rd_word;
  logic           unused_addr;

  assign unused_addr  = ^dm_addr;
  assign in_range_err = (dm_addr >> (AW + B)) != '0;
  assign dump_rise    = dump & ~dump_q;
  assign pend_eff     = pend_q | dump_rise;
  assign ack          = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign wr_en        = ack & we_q & ~err_q & ~reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_eff) begin
          state_d = ST_DUMP;
          ptr_d   = '0;
          pend_d  = 1'b0;
        end else if (dm_req) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(LATENCY - 1);
          accept  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dump_rise) pend_d = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (pend_eff) begin
          // Dump queued behind the access starts straight after its ack.
          state_d = ST_DUMP;
          ptr_d   = '0;
          pend_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DUMP: begin
        pend_d = 1'b0;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == PTR_END) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      ptr_q        <= '0;
      pend_q       <= 1'b0;
      dump_q       <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      dump_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      pend_q       <= pend_d;
      dump_q       <= dump;
      // Beats trail the read pointer by one cycle because the RAM read is registered.
      dump_valid_q <= (state_q == ST_DUMP) && !ptr_q[AW];
      dump_idx_q   <= ((state_q == ST_DUMP) && !ptr_q[AW]) ? ptr_q[AW-1:0] : '0;
      dump_done_q  <= (state_q == ST_DUMP) && ptr_q[AW];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= dm_addr[AW+B-1:B];
      we_q    <= dm_we;
      err_q   <= in_range_err;
      wdata_q <= dm_wdata;
    end
  end

`ifdef DMEM_BYTE_STROBE_EN
  logic [NB-1:0] be_q;
  always_ff @(posedge clk) begin
    if (accept) be_q <= dm_be;
  end
  assign wr_be = be_q;
`else
  assign wr_be = '1;
`endif

  // Read the incoming address while idle so data is ready even for LATENCY=1.
  always_comb begin
    rd_addr = idx_q;
    if (state_q == ST_DUMP)      rd_addr = ptr_q[AW-1:0];
    else if (state_q == ST_IDLE) rd_addr = dm_addr[AW+B-1:B];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];
      logic [7:0] rd_lane_q;
      always_ff @(posedge clk) begin
        if (wr_en && wr_be[gi]) mem_lane[idx_q] <= wdata_q[gi*8 +: 8];
        rd_lane_q <= mem_lane[rd_addr];
      end
      assign rd_word[gi*8 +: 8] = rd_lane_q;
    end
  endgenerate

  assign dm_ack     = ack;
  assign dm_err     = ack & err_q;
  assign dm_rdata   = (ack && !err_q) ? rd_word : '0;
  assign dm_stall   = (dm_req & ~ack) | (state_q == ST_DUMP);
  assign dump_valid = dump_valid_q;
  assign dump_idx   = dump_idx_q;
  assign dump_data  = dump_valid_q ? rd_word : '0;
  assign dump_done  = dump_done_q;

endmodule
